// File: rtl/piso_nbit_hs_pkg.sv
// Shared types and helpers for the handshaked parallel-in/serial-out stage.
package piso_nbit_hs_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bit-counter width; never below 1 so N=1 still gets a real register.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/piso_nbit_hs_word_hold_reg.sv
// One-word holding buffer: W-bit register with load, clear and a full flag.
module piso_nbit_hs_word_hold_reg
   import piso_nbit_hs_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         full
);

   logic [W-1:0] data_q, data_d;
   logic         full_q, full_d;

   // Clear wins; load and clear are never requested together by the owner.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (clr) begin
         data_d = '0;
         full_d = 1'b0;
      end else if (load) begin
         data_d = d;
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign q    = data_q;
   assign full = full_q;

endmodule

// File: rtl/piso_nbit_hs.sv
// Parallel-in/serial-out stage, LSB first, with valid/ready input and framing flags.
//
//   state    | meaning
//   ST_IDLE  | no word shifting, ser_* outputs low
//   ST_SHIFT | shift reg bit 0 is on ser_out, counter tracks bit index
module piso_nbit_hs
   import piso_nbit_hs_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_al_in,
   input  logic [N-1:0] par_in,
   input  logic         par_valid_in,
   output logic         par_ready_out,
   output logic         ser_out,
   output logic         ser_valid_out,
   output logic         ser_first_out,
   output logic         ser_last_out,
   output logic         busy_out
);

   localparam int               CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t             state_q, state_d;
   logic [N-1:0]       shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               hold_load, hold_clr, hold_full;
   logic [N-1:0]       hold_q;
   logic               xfer, in_shift, last_bit;

   piso_nbit_hs_word_hold_reg #(.W(N)) u_hold (
      .clk   (clk),
      .rst_n (reset_al_in),
      .load  (hold_load),
      .clr   (hold_clr),
      .d     (par_in),
      .q     (hold_q),
      .full  (hold_full)
   );

   assign par_ready_out = reset_al_in & ~hold_full;
   assign xfer          = par_valid_in & par_ready_out;
   assign in_shift      = (state_q == ST_SHIFT);
   assign last_bit      = (cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      hold_load = 1'b0;
      hold_clr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               shift_d = par_in;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               // Held word has priority; ready is low then, so no transfer can collide.
               cnt_d = '0;
               if (hold_full) begin
                  shift_d  = hold_q;
                  hold_clr = 1'b1;
               end else if (xfer) begin
                  shift_d = par_in;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer) begin
               hold_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ser_out       = in_shift & shift_q[0];
   assign ser_valid_out = in_shift;
   assign ser_first_out = in_shift & (cnt_q == '0);
   assign ser_last_out  = in_shift & last_bit;
   assign busy_out      = in_shift | hold_full;

endmodule

// File: tb/tb_piso_nbit_hs.sv
// Scoreboard bench for piso_nbit_hs at N=4 and N=1.
module tb_piso_nbit_hs;

   typedef struct {
      logic b;
      logic f;
      logic l;
      int   cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] pin4;
   logic       pv4, rdy4, so4, sv4, sf4, sl4, busy4;
   logic [0:0] pin1;
   logic       pv1, rdy1, so1, sv1, sf1, sl1, busy1;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   last4  = -100;
   int   last1  = -100;
   exp_t q4[$];
   exp_t q1[$];

   piso_nbit_hs #(.N(4)) dut4 (
      .clk           (clk),
      .reset_al_in   (rst_n),
      .par_in        (pin4),
      .par_valid_in  (pv4),
      .par_ready_out (rdy4),
      .ser_out       (so4),
      .ser_valid_out (sv4),
      .ser_first_out (sf4),
      .ser_last_out  (sl4),
      .busy_out      (busy4)
   );

   piso_nbit_hs #(.N(1)) dut1 (
      .clk           (clk),
      .reset_al_in   (rst_n),
      .par_in        (pin1),
      .par_valid_in  (pv1),
      .par_ready_out (rdy1),
      .ser_out       (so1),
      .ser_valid_out (sv1),
      .ser_first_out (sf1),
      .ser_last_out  (sl1),
      .busy_out      (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_word4(input logic [3:0] w, input int e);
      int start;
      start = (e > last4) ? e : last4 + 1;
      for (int i = 0; i < 4; i++) q4.push_back('{w[i], (i == 0), (i == 3), start + i});
      last4 = start + 3;
   endtask

   task automatic push_word1(input logic w, input int e);
      int start;
      start = (e > last1) ? e : last1 + 1;
      q1.push_back('{w, 1'b1, 1'b1, start});
      last1 = start;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send4(input logic [3:0] w, output int e);
      int n;
      bit done;
      n = 0;
      done = 0;
      pin4 = w;
      pv4 = 1'b1;
      while (!done && n < 50) begin
         @(negedge clk);
         if (rdy4 === 1'b1) done = 1;
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept4", done, 1);
      e = done ? cyc : -1;
      if (done) push_word4(w, e);
   endtask

   task automatic send1(input logic w, output int e);
      int n;
      bit done;
      n = 0;
      done = 0;
      pin1 = w;
      pv1 = 1'b1;
      while (!done && n < 50) begin
         @(negedge clk);
         if (rdy1 === 1'b1) done = 1;
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept1", done, 1);
      e = done ? cyc : -1;
      if (done) push_word1(w, e);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (rst_n) begin
         if (sv4) begin
            if (q4.size() == 0) begin
               chk("unexpected_bit4", 1, 0);
            end else begin
               x = q4.pop_front();
               chk("bit4", so4, x.b);
               chk("first4", sf4, x.f);
               chk("last4", sl4, x.l);
               chk("cycle4", cyc, x.cyc);
            end
         end else begin
            chk("idle_out4", {so4, sf4, sl4}, 0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t x;
      if (rst_n) begin
         if (sv1) begin
            if (q1.size() == 0) begin
               chk("unexpected_bit1", 1, 0);
            end else begin
               x = q1.pop_front();
               chk("bit1", so1, x.b);
               chk("first1", sf1, x.f);
               chk("last1", sl1, x.l);
               chk("cycle1", cyc, x.cyc);
            end
         end else begin
            chk("idle_out1", {so1, sf1, sl1}, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int ea, e3, ef, e5, e2, e6, e9, b0, b1, b2;
      rst_n = 1'b0;
      pin4 = '0;
      pv4 = 1'b0;
      pin1 = '0;
      pv1 = 1'b0;
      #2;
      chk("rst_ready4", rdy4, 0);
      chk("rst_valid4", sv4, 0);
      chk("rst_busy4", busy4, 0);
      chk("rst_ready1", rdy1, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      repeat (5) begin
         @(negedge clk);
         chk("idle_ready4", rdy4, 1);
         chk("idle_busy4", busy4, 0);
         chk("idle_ready1", rdy1, 1);
      end

      // single word 1011
      @(posedge clk);
      #1;
      send4(4'b1011, ea);
      pv4 = 1'b0;
      chk("busy_shift4", busy4, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("back_idle_busy4", busy4, 0);
      chk("back_idle_valid4", sv4, 0);

      // stream A,3,F with valid held high
      @(posedge clk);
      #1;
      send4(4'hA, ea);
      send4(4'h3, e3);
      send4(4'hF, ef);
      pv4 = 1'b0;
      chk("accept_gap_3", e3 - ea, 1);
      chk("accept_gap_F", ef - ea, 5);
      repeat (14) @(posedge clk);
      #1;
      chk("stream_drained", q4.size(), 0);
      chk("stream_busy", busy4, 0);

      // word offered right at last bit: direct load into shift reg
      send4(4'h5, e5);
      pv4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send4(4'h2, e2);
      pv4 = 1'b0;
      chk("direct_load_gap", e2 - e5, 4);
      repeat (10) @(posedge clk);
      #1;
      chk("direct_drained", q4.size(), 0);

      // reset during bit 2 of 6 with 9 held
      send4(4'h6, e6);
      send4(4'h9, e9);
      pv4 = 1'b0;
      chk("held_gap", e9 - e6, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", sv4, 0);
      chk("abort_out", so4, 0);
      chk("abort_busy", busy4, 0);
      chk("abort_ready", rdy4, 0);
      chk("abort_pending", q4.size(), 6);
      q4.delete();
      last4 = -100;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("post_abort_busy", busy4, 0);
         chk("post_abort_ready", rdy4, 1);
      end

      // N=1 stream 1,0,1
      @(posedge clk);
      #1;
      send1(1'b1, b0);
      send1(1'b0, b1);
      send1(1'b1, b2);
      pv1 = 1'b0;
      chk("n1_gap1", b1 - b0, 1);
      chk("n1_gap2", b2 - b0, 2);
      repeat (4) @(posedge clk);
      #1;
      chk("n1_drained", q1.size(), 0);
      chk("n1_busy", busy1, 0);
      chk("n4_final_queue", q4.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
